led_stretch_pwm: RTL and testbench
==================================

LED_STRETCH_PWM -- requirements
Module: led_stretch_pwm

Interface
REQ-001 SHALL have parameter WIDTH, default 8: number of LED channels; matches the 8-bit GPIO LED bus.
REQ-002 SHALL have parameter CNT_W, default 24: width of each per-channel stretch counter.
REQ-003 SHALL have parameter STRETCH_CYCLES, default 10000000: extra on-time after an input falls (100 ms at 100 MHz); legal range 0..2^CNT_W-1.
REQ-004 SHALL have parameter PWM_W, default 4: width of the brightness value and the PWM counter.
REQ-005 SHALL have port CLK, input, 1 bit: the single clock, driven by the fabric clock that also clocks the LED source.
REQ-006 SHALL have port RST, input, 1 bit: reset, synchronous and active-high.
REQ-007 SHALL have port leds_in, input, WIDTH bits: raw LED levels from the design's leds output.
REQ-008 SHALL have port stretch_en, input, 1 bit: 1 enables stretching; 0 gives pass-through.
REQ-009 SHALL have port brightness, input, PWM_W bits: duty value.
REQ-010 SHALL have port leds_out, output, WIDTH bits: modulated LED drive to the GPIO_leds pins.
REQ-011 SHALL have port active, output, WIDTH bits: stretched, unmodulated channel state for status readback.

Function
REQ-012 SHALL register leds_in into leds_q on every CLK edge.
REQ-013 Per channel i, when leds_q[i]=1 and stretch_en=1, SHALL load cnt[i] with STRETCH_CYCLES.
REQ-014 When leds_q[i]=0 and cnt[i]!=0, SHALL decrement cnt[i] by 1.
REQ-015 SHALL saturate cnt[i] at 0; no wrap below zero.
REQ-016 SHALL reload cnt[i] while the input is held high; a retrigger during stretch restarts the full STRETCH_CYCLES.
REQ-017 When stretch_en=0, SHALL force all cnt to 0 on the next edge.
REQ-018 SHALL register active[i] each edge from (leds_q[i] OR cnt[i]!=0), using values before that edge.
REQ-019 SHALL run a PWM counter pwm that counts 0..2^PWM_W-2 and then wraps to 0, giving a period of 2^PWM_W-1 cycles.
REQ-020 SHALL compute pwm_on = (pwm < brightness).
  - brightness=0: always off.
  - brightness=2^PWM_W-1: always on.
REQ-021 SHALL register leds_out each edge from (leds_q OR cnt!=0) AND pwm_on, per bit, using pre-edge values.
REQ-022 Latency: leds_in first sampled 1 at edge k gives leds_out/active = 1 after edge k+1, provided pwm_on holds for leds_out.
REQ-023 Stretch: leds_in first sampled 0 at edge m gives active[i] = 1 through edge m+STRETCH_CYCLES and 0 after edge m+STRETCH_CYCLES+1, absent retrigger.
REQ-024 With STRETCH_CYCLES=0 or stretch_en=0, active SHALL equal leds_q delayed one cycle (pure pass-through).
REQ-025 A brightness change SHALL take effect on the next edge with no wait for period end; the pwm phase is unaffected.
REQ-026 Channels SHALL be fully independent; simultaneous events on different bits SHALL not interact.
REQ-027 A stretch_en 1->0 mid-stretch SHALL drop active for channels with leds_q=0 after 2 edges.

Reset
REQ-028 While RST=1 at an edge, SHALL clear leds_q, all cnt, pwm, active and leds_out to 0, regardless of other inputs.
REQ-029 Reset mid-stretch SHALL discard pending stretch; after RST falls, behaviour restarts as from power-up, with pwm starting at 0.

Verification (bench params: WIDTH=8, STRETCH_CYCLES=4, PWM_W=2 -> period 3; CNT_W=24)
REQ-030 Scenario: RST=1 for 2 cycles, leds_in=8'hFF, brightness=3 -> leds_out=8'h00 and active=8'h00 during reset and on the first edge after release; both 8'hFF from the second edge after release.
REQ-031 Scenario: stretch_en=1, brightness=3, one-cycle pulse on leds_in[0] sampled at edge k -> leds_out[0]=1 after edges k+1..k+5 (exactly 5 cycles), 0 after k+6; other bits 0.
REQ-032 Scenario: pulse bit0 at edge k, second pulse at k+3 -> leds_out[0] stays 1 continuously through k+8 and falls after k+9.
REQ-033 Scenario: stretch_en=0, brightness=3, one-cycle pulse on leds_in[3] -> leds_out[3]=1 for exactly 1 cycle, 2 edges after the leds_in change.
REQ-034 Scenario: leds_in=8'hFF steady, brightness=1 -> leds_out=8'hFF for 1 of every 3 cycles and 8'h00 for 2; brightness=0 -> leds_out=8'h00 constantly while active=8'hFF.
REQ-035 Scenario: stretch bit7 running (cnt=3), assert RST for one edge -> active[7]=0 and leds_out[7]=0 immediately after that edge, remaining 0 with leds_in=0.

Source files
------------

// File: rtl/led_stretch_pwm.sv
// led_stretch_pwm: per-channel pulse stretcher followed by a shared PWM dimmer.
// Short LED pulses are held on for STRETCH_CYCLES extra clocks so they stay visible.
// All channels share one brightness PWM. Every output is registered.
module led_stretch_pwm #(
    parameter int WIDTH          = 8,
    parameter int CNT_W          = 24,
    parameter int STRETCH_CYCLES = 10000000,
    parameter int PWM_W          = 4
) (
    input  logic             CLK,
    input  logic             RST,
    input  logic [WIDTH-1:0] leds_in,
    input  logic             stretch_en,
    input  logic [PWM_W-1:0] brightness,
    output logic [WIDTH-1:0] leds_out,
    output logic [WIDTH-1:0] active
);

    // Reload value for a stretch. It is truncated to the counter width.
    localparam logic [CNT_W-1:0] STRETCH_LOAD = CNT_W'(STRETCH_CYCLES);
    // The last PWM count is 2^PWM_W-2. The period is therefore 2^PWM_W-1.
    // This lets brightness = all-ones mean fully on.
    localparam logic [PWM_W-1:0] PWM_LAST = ~(PWM_W'(1));

    logic [WIDTH-1:0] r_leds_q;
    logic [PWM_W-1:0] r_pwm;
    logic [WIDTH-1:0] r_active;
    logic [WIDTH-1:0] r_leds_out;
    logic [WIDTH-1:0] w_busy;
    logic             w_pwm_on;

    // Input sampling register. All per-channel decisions are based on this sample.
    always_ff @(posedge CLK) begin
        if (RST) begin
            r_leds_q <= '0;
        end else begin
            r_leds_q <= leds_in;
        end
    end

    // Free-running PWM phase. The phase is independent of brightness,
    // so a new duty value takes effect at once.
    always_ff @(posedge CLK) begin
        if (RST) begin
            r_pwm <= '0;
        end else if (r_pwm == PWM_LAST) begin
            r_pwm <= '0;
        end else begin
            r_pwm <= r_pwm + PWM_W'(1);
        end
    end

    assign w_pwm_on = (r_pwm < brightness);

    genvar gi;
    generate
        for (gi = 0; gi < WIDTH; gi = gi + 1) begin : g_ch
            logic [CNT_W-1:0] r_cnt;

            // A channel is lit while its sampled input is high or a stretch is pending.
            assign w_busy[gi] = r_leds_q[gi] | (r_cnt != '0);

            // Stretch counter.
            // It reloads while the input is high and counts down to zero once the input is low.
            // It is cleared while stretching is disabled.
            always_ff @(posedge CLK) begin
                if (RST) begin
                    r_cnt <= '0;
                end else if (!stretch_en) begin
                    r_cnt <= '0;
                end else if (r_leds_q[gi]) begin
                    r_cnt <= STRETCH_LOAD;
                end else if (r_cnt != '0) begin
                    r_cnt <= r_cnt - CNT_W'(1);
                end
            end

            // Output registers.
            // The status bit carries the raw stretched state.
            // The drive bit is that state gated by the PWM.
            always_ff @(posedge CLK) begin
                if (RST) begin
                    r_active[gi]   <= 1'b0;
                    r_leds_out[gi] <= 1'b0;
                end else begin
                    r_active[gi]   <= w_busy[gi];
                    r_leds_out[gi] <= w_busy[gi] & w_pwm_on;
                end
            end
        end
    endgenerate

    assign active   = r_active;
    assign leds_out = r_leds_out;

endmodule

// File: tb/tb_led_stretch_pwm.sv
// Testbench for led_stretch_pwm, built with STRETCH_CYCLES=4 and PWM_W=2 (PWM period 3).
// The stimulus process drives one vector per cycle.
// Each vector carries the hand-computed outputs expected right after the next edge.
// Those expected outputs go into a queue. A monitor process pops one entry after every edge and compares it.
module tb_led_stretch_pwm;

    logic       CLK = 1'b0;
    logic       RST = 1'b1;
    logic [7:0] leds_in = 8'h00;
    logic       stretch_en = 1'b1;
    logic [1:0] brightness = 2'd3;
    logic [7:0] leds_out;
    logic [7:0] active;

    typedef struct {
        string      name;
        logic [7:0] exp_out;
        logic [7:0] exp_act;
    } exp_t;

    exp_t sb[$];
    int   tests  = 0;
    int   errors = 0;
    bit   stim_done = 1'b0;

    led_stretch_pwm #(
        .WIDTH(8),
        .CNT_W(24),
        .STRETCH_CYCLES(4),
        .PWM_W(2)
    ) dut (
        .CLK(CLK),
        .RST(RST),
        .leds_in(leds_in),
        .stretch_en(stretch_en),
        .brightness(brightness),
        .leds_out(leds_out),
        .active(active)
    );

    always #5 CLK = ~CLK;

    // Drive one vector on the falling edge.
    // Queue the outputs expected after the following rising edge.
    task automatic cyc(input logic r, input logic [7:0] li, input logic en,
                       input logic [1:0] br, input logic [7:0] eo,
                       input logic [7:0] ea, input string nm);
        exp_t e;
        @(negedge CLK);
        RST        = r;
        leds_in    = li;
        stretch_en = en;
        brightness = br;
        e.name    = nm;
        e.exp_out = eo;
        e.exp_act = ea;
        sb.push_back(e);
    endtask

    task automatic do_reset(input logic en, input logic [1:0] br);
        cyc(1'b1, 8'h00, en, br, 8'h00, 8'h00, "reset");
        cyc(1'b1, 8'h00, en, br, 8'h00, 8'h00, "reset");
    endtask

    // Monitor: after each rising edge, pop one expectation and compare both outputs.
    initial begin
        exp_t e;
        forever begin
            @(posedge CLK);
            #1;
            if (sb.size() > 0) begin
                e = sb.pop_front();
                tests++;
                if (leds_out !== e.exp_out) begin
                    errors++;
                    $display("FAIL %s leds_out: got %h expected %h", e.name, leds_out, e.exp_out);
                end
                tests++;
                if (active !== e.exp_act) begin
                    errors++;
                    $display("FAIL %s active: got %h expected %h", e.name, active, e.exp_act);
                end
                $display("[TB] %-10s leds_out=%h active=%h (exp %h/%h)",
                         e.name, leds_out, active, e.exp_out, e.exp_act);
            end
        end
    end

    // Stimulus.
    initial begin
        // Reset while the inputs are all high. Outputs appear on the second edge after release.
        cyc(1'b1, 8'hFF, 1'b1, 2'd3, 8'h00, 8'h00, "rst_hold");
        cyc(1'b1, 8'hFF, 1'b1, 2'd3, 8'h00, 8'h00, "rst_hold");
        cyc(1'b0, 8'hFF, 1'b1, 2'd3, 8'h00, 8'h00, "rel_1");     // pre-edge pwm 0
        cyc(1'b0, 8'hFF, 1'b1, 2'd3, 8'hFF, 8'hFF, "rel_2");     // pre-edge pwm 1
        cyc(1'b0, 8'hFF, 1'b1, 2'd3, 8'hFF, 8'hFF, "full");      // pre-edge pwm 2
        // brightness=1: on only in pwm phase 0.
        cyc(1'b0, 8'hFF, 1'b1, 2'd1, 8'hFF, 8'hFF, "br1_p0");
        cyc(1'b0, 8'hFF, 1'b1, 2'd1, 8'h00, 8'hFF, "br1_p1");
        cyc(1'b0, 8'hFF, 1'b1, 2'd1, 8'h00, 8'hFF, "br1_p2");
        cyc(1'b0, 8'hFF, 1'b1, 2'd1, 8'hFF, 8'hFF, "br1_p0");
        cyc(1'b0, 8'hFF, 1'b1, 2'd1, 8'h00, 8'hFF, "br1_p1");
        cyc(1'b0, 8'hFF, 1'b1, 2'd1, 8'h00, 8'hFF, "br1_p2");
        // brightness=0: always off while still active.
        cyc(1'b0, 8'hFF, 1'b1, 2'd0, 8'h00, 8'hFF, "br0");
        cyc(1'b0, 8'hFF, 1'b1, 2'd0, 8'h00, 8'hFF, "br0");
        cyc(1'b0, 8'hFF, 1'b1, 2'd0, 8'h00, 8'hFF, "br0");
        // brightness=2: on in pwm phases 0 and 1.
        cyc(1'b0, 8'hFF, 1'b1, 2'd2, 8'hFF, 8'hFF, "br2_p0");
        cyc(1'b0, 8'hFF, 1'b1, 2'd2, 8'hFF, 8'hFF, "br2_p1");
        cyc(1'b0, 8'hFF, 1'b1, 2'd2, 8'h00, 8'hFF, "br2_p2");

        // Single pulse on bit 0 is stretched to exactly 5 cycles.
        do_reset(1'b1, 2'd3);
        cyc(1'b0, 8'h00, 1'b1, 2'd3, 8'h00, 8'h00, "idle");
        cyc(1'b0, 8'h01, 1'b1, 2'd3, 8'h00, 8'h00, "pulse_k");
        cyc(1'b0, 8'h00, 1'b1, 2'd3, 8'h01, 8'h01, "str_k1");
        cyc(1'b0, 8'h00, 1'b1, 2'd3, 8'h01, 8'h01, "str_k2");
        cyc(1'b0, 8'h00, 1'b1, 2'd3, 8'h01, 8'h01, "str_k3");
        cyc(1'b0, 8'h00, 1'b1, 2'd3, 8'h01, 8'h01, "str_k4");
        cyc(1'b0, 8'h00, 1'b1, 2'd3, 8'h01, 8'h01, "str_k5");
        cyc(1'b0, 8'h00, 1'b1, 2'd3, 8'h00, 8'h00, "str_k6");
        cyc(1'b0, 8'h00, 1'b1, 2'd3, 8'h00, 8'h00, "str_k7");

        // A retrigger at k+3 restarts the full stretch.
        do_reset(1'b1, 2'd3);
        cyc(1'b0, 8'h01, 1'b1, 2'd3, 8'h00, 8'h00, "rt_k");
        cyc(1'b0, 8'h00, 1'b1, 2'd3, 8'h01, 8'h01, "rt_k1");
        cyc(1'b0, 8'h00, 1'b1, 2'd3, 8'h01, 8'h01, "rt_k2");
        cyc(1'b0, 8'h01, 1'b1, 2'd3, 8'h01, 8'h01, "rt_k3");
        cyc(1'b0, 8'h00, 1'b1, 2'd3, 8'h01, 8'h01, "rt_k4");
        cyc(1'b0, 8'h00, 1'b1, 2'd3, 8'h01, 8'h01, "rt_k5");
        cyc(1'b0, 8'h00, 1'b1, 2'd3, 8'h01, 8'h01, "rt_k6");
        cyc(1'b0, 8'h00, 1'b1, 2'd3, 8'h01, 8'h01, "rt_k7");
        cyc(1'b0, 8'h00, 1'b1, 2'd3, 8'h01, 8'h01, "rt_k8");
        cyc(1'b0, 8'h00, 1'b1, 2'd3, 8'h00, 8'h00, "rt_k9");
        cyc(1'b0, 8'h00, 1'b1, 2'd3, 8'h00, 8'h00, "rt_k10");

        // With stretching disabled, the output is a pure pass-through delayed by two edges.
        do_reset(1'b0, 2'd3);
        cyc(1'b0, 8'h08, 1'b0, 2'd3, 8'h00, 8'h00, "pass_k");
        cyc(1'b0, 8'h00, 1'b0, 2'd3, 8'h08, 8'h08, "pass_k1");
        cyc(1'b0, 8'h00, 1'b0, 2'd3, 8'h00, 8'h00, "pass_k2");
        cyc(1'b0, 8'h00, 1'b0, 2'd3, 8'h00, 8'h00, "pass_k3");

        // Turning stretch_en off mid-stretch drops active two edges later.
        do_reset(1'b1, 2'd3);
        cyc(1'b0, 8'h01, 1'b1, 2'd3, 8'h00, 8'h00, "dis_k");
        cyc(1'b0, 8'h00, 1'b1, 2'd3, 8'h01, 8'h01, "dis_k1");
        cyc(1'b0, 8'h00, 1'b0, 2'd3, 8'h01, 8'h01, "dis_k2");
        cyc(1'b0, 8'h00, 1'b0, 2'd3, 8'h00, 8'h00, "dis_k3");

        // Overlapping pulses on two channels stay independent.
        do_reset(1'b1, 2'd3);
        cyc(1'b0, 8'h02, 1'b1, 2'd3, 8'h00, 8'h00, "ind_k");
        cyc(1'b0, 8'h04, 1'b1, 2'd3, 8'h02, 8'h02, "ind_k1");
        cyc(1'b0, 8'h00, 1'b1, 2'd3, 8'h06, 8'h06, "ind_k2");
        cyc(1'b0, 8'h00, 1'b1, 2'd3, 8'h06, 8'h06, "ind_k3");
        cyc(1'b0, 8'h00, 1'b1, 2'd3, 8'h06, 8'h06, "ind_k4");
        cyc(1'b0, 8'h00, 1'b1, 2'd3, 8'h06, 8'h06, "ind_k5");
        cyc(1'b0, 8'h00, 1'b1, 2'd3, 8'h04, 8'h04, "ind_k6");
        cyc(1'b0, 8'h00, 1'b1, 2'd3, 8'h00, 8'h00, "ind_k7");

        // A reset during a stretch discards it.
        do_reset(1'b1, 2'd3);
        cyc(1'b0, 8'h80, 1'b1, 2'd3, 8'h00, 8'h00, "mr_k");
        cyc(1'b0, 8'h00, 1'b1, 2'd3, 8'h80, 8'h80, "mr_k1");
        cyc(1'b0, 8'h00, 1'b1, 2'd3, 8'h80, 8'h80, "mr_k2");
        cyc(1'b1, 8'h00, 1'b1, 2'd3, 8'h00, 8'h00, "mr_rst");
        cyc(1'b0, 8'h00, 1'b1, 2'd3, 8'h00, 8'h00, "mr_after1");
        cyc(1'b0, 8'h00, 1'b1, 2'd3, 8'h00, 8'h00, "mr_after2");
        cyc(1'b0, 8'h00, 1'b1, 2'd3, 8'h00, 8'h00, "mr_after3");

        stim_done = 1'b1;
    end

    // Completion: wait, within a bound, for the scoreboard to drain, then print the summary.
    initial begin
        int budget;
        budget = 0;
        while (!stim_done && budget < 2000) begin
            @(posedge CLK);
            budget++;
        end
        budget = 0;
        while (sb.size() > 0 && budget < 20) begin
            @(posedge CLK);
            budget++;
        end
        #2;
        tests++;
        if (!stim_done || sb.size() != 0) begin
            errors++;
            $display("FAIL drain: stim_done=%0d pending=%0d expected 1/0", stim_done, sb.size());
        end
        $display("[TB] %0d tests run, %0d failed", tests, errors);
        $finish;
    end

endmodule
